// File: rtl/lc3_pkg.sv
// Shared LC3 definitions for the memory unit.
//   LC3_WORD_W / LC3_ADDR_W : architectural word and address widths.
//   mem_state_e             : memory unit FSM encoding (IDLE/WAIT/ACCESS).
package lc3_pkg;

  localparam int LC3_WORD_W = 16;
  localparam int LC3_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10
  } mem_state_e;

endpackage

// File: rtl/lc3_sram_1p.sv
// Single-port synchronous RAM.
//   clk   : rising-edge clock
//   we    : write enable, writes wdata to addr at the edge
//   addr  : word address (MEM_AW bits)
//   wdata : write data
//   rdata : registered read data, mem[addr] as seen before the edge (read-first)
// Contents are never cleared; there is no reset.
module lc3_sram_1p #(
  parameter int MEM_AW = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_unit.sv
// Multi-cycle LC3 main memory with wait states.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   mem_en   : access request, held high by the controller until ready
//   r_w      : 1 = write, 0 = read (latched on acceptance)
//   addr     : MAR address; only addr[MEM_AW-1:0] decodes, upper bits alias
//   din      : MDR write data (latched on acceptance)
//   dout     : last completed read value; writes leave it untouched
//   ready    : one-cycle completion pulse (LC3 "R")
// Handshake: a request is accepted at an edge where the FSM is IDLE and
// mem_en=1. It completes at the edge leaving ACCESS only if mem_en is still
// high; ready is high for the cycle after that edge. Dropping mem_en at any
// earlier edge aborts with no write, no ready and no dout change. Holding
// mem_en through the ready cycle starts the next access immediately.
// The FSM state is held in state_q (mem_state_e) for observation.
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W      = LC3_WORD_W,
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic                  r_w,
  input  logic [LC3_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  ready
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ready_q, ready_d;

  logic              commit;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[LC3_ADDR_W-1:MEM_AW];

  assign commit = (state_q == ST_ACCESS) && mem_en;
  assign ram_we = commit && wr_q && !rst;

  // In IDLE the RAM reads the live address so that with zero wait states
  // the data is already registered by the time the ACCESS cycle commits.
  assign ram_addr = (state_q == ST_IDLE) ? addr[MEM_AW-1:0] : addr_q;

  lc3_sram_1p #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          addr_d  = addr[MEM_AW-1:0];
          din_d   = din;
          wr_d    = r_w;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_en) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_ACCESS;
          end
          cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (commit) begin
          ready_d = 1'b1;
          if (!wr_q) begin
            dout_d = ram_rdata;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  assign dout  = dout_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Bench for lc3_mem_unit: one instance with 3 wait states, one with none.
// A word-array reference model (indexed by address modulo the depth) and an
// expected-dout register predict every completed access.
module tb_lc3_mem_unit;

  localparam int NWAIT0 = 3;
  localparam int NWAIT1 = 0;
  localparam int DEPTH  = 1024;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        mem_en [2];
  logic        r_w    [2];
  logic [15:0] addr   [2];
  logic [15:0] din    [2];
  logic [15:0] dout   [2];
  logic        ready  [2];

  lc3_mem_unit #(.DATA_W(16), .MEM_AW(10), .WAIT_CYCLES(NWAIT0)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_en(mem_en[0]), .r_w(r_w[0]),
    .addr(addr[0]), .din(din[0]), .dout(dout[0]), .ready(ready[0])
  );

  lc3_mem_unit #(.DATA_W(16), .MEM_AW(10), .WAIT_CYCLES(NWAIT1)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_en(mem_en[1]), .r_w(r_w[1]),
    .addr(addr[1]), .din(din[1]), .dout(dout[1]), .ready(ready[1])
  );

  // scoreboard / reference model
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model    [2][DEPTH];
  bit          written  [2][DEPTH];
  logic [15:0] exp_dout [2];

  function automatic int nwait(input int s);
    return (s == 0) ? NWAIT0 : NWAIT1;
  endfunction

  function automatic int widx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic check_eq(input string tag, input int s,
                          input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s inst%0d observed=%h expected=%h t=%0t", tag, s, obs, exp, $time);
    end
  endtask

  // driver tasks: each starts and ends just after a negedge
  task automatic access(input int s, input bit we, input logic [15:0] a,
                        input logic [15:0] d, input int abort_after, input bit keep);
    mem_en[s] = 1'b1;
    r_w[s]    = we;
    addr[s]   = a;
    din[s]    = d;
    @(posedge clk); #1;
    check_eq("accept_ready_low", s, 32'(ready[s]), 32'd0);
    // post-acceptance changes must be ignored
    addr[s] = 16'($urandom);
    din[s]  = 16'($urandom);
    r_w[s]  = 1'($urandom_range(0, 1));
    if (abort_after >= 0) begin
      repeat (abort_after) @(posedge clk);
      @(negedge clk);
      mem_en[s] = 1'b0;
      for (int i = 0; i < nwait(s) + 3; i++) begin
        @(posedge clk); #1;
        check_eq("abort_no_ready", s, 32'(ready[s]), 32'd0);
      end
      check_eq("abort_dout", s, 32'(dout[s]), 32'(exp_dout[s]));
      @(negedge clk);
    end else begin
      for (int i = 1; i <= nwait(s) + 1; i++) begin
        @(posedge clk); #1;
        if (i == nwait(s) + 1) begin
          if (we) begin
            model[s][widx(a)]   = d;
            written[s][widx(a)] = 1'b1;
          end else begin
            exp_dout[s] = model[s][widx(a)];
          end
        end
        check_eq("ready_timing", s, 32'(ready[s]), 32'(i == nwait(s) + 1));
      end
      check_eq("dout", s, 32'(dout[s]), 32'(exp_dout[s]));
      @(negedge clk);
      if (!keep) mem_en[s] = 1'b0;
    end
  endtask

  task automatic reset_test(input int s);
    rst[s]    = 1'b1;
    mem_en[s] = 1'b1;
    r_w[s]    = 1'b1;
    addr[s]   = 16'($urandom);
    din[s]    = 16'($urandom);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("reset_ready", s, 32'(ready[s]), 32'd0);
      check_eq("reset_dout", s, 32'(dout[s]), 32'd0);
    end
    @(negedge clk);
    rst[s]      = 1'b0;
    mem_en[s]   = 1'b0;
    exp_dout[s] = 16'h0000;
    for (int i = 0; i < nwait(s) + 3; i++) begin
      @(posedge clk); #1;
      check_eq("post_reset_idle", s, 32'(ready[s]), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic reset_mid_write(input int s, input logic [15:0] a, input logic [15:0] d);
    mem_en[s] = 1'b1;
    r_w[s]    = 1'b1;
    addr[s]   = a;
    din[s]    = d;
    @(posedge clk);
    if (nwait(s) > 0) @(posedge clk);
    @(negedge clk);
    rst[s] = 1'b1;
    @(posedge clk); #1;
    exp_dout[s] = 16'h0000;
    check_eq("midrst_ready", s, 32'(ready[s]), 32'd0);
    check_eq("midrst_dout", s, 32'(dout[s]), 32'd0);
    @(negedge clk);
    rst[s]    = 1'b0;
    mem_en[s] = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_idle", s, 32'(ready[s]), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_suite(input int s);
    int         op;
    logic [15:0] a;
    logic [9:0]  idx;
    bit          keep;

    reset_test(s);

    access(s, 1'b1, 16'h0056, 16'hABCD, -1, 1'b0);
    access(s, 1'b0, 16'h0056, 16'h0000, -1, 1'b0);
    check_eq("rd_0056", s, 32'(dout[s]), 32'h0000ABCD);

    access(s, 1'b1, 16'h0456, 16'h1234, -1, 1'b0);
    access(s, 1'b0, 16'h0056, 16'h0000, -1, 1'b0);
    check_eq("alias_0056", s, 32'(dout[s]), 32'h00001234);

    access(s, 1'b1, 16'h0010, 16'hC0DE, -1, 1'b0);
    access(s, 1'b1, 16'h0010, 16'h5555, (nwait(s) >= 2) ? 2 : 0, 1'b0);
    access(s, 1'b0, 16'h0010, 16'h0000, -1, 1'b0);
    check_eq("abort_keeps_0010", s, 32'(dout[s]), 32'h0000C0DE);

    access(s, 1'b1, 16'h0057, 16'h5757, -1, 1'b0);
    access(s, 1'b1, 16'h0058, 16'h5858, -1, 1'b0);
    access(s, 1'b0, 16'h0056, 16'h0000, -1, 1'b1);
    access(s, 1'b0, 16'h0057, 16'h0000, -1, 1'b1);
    check_eq("b2b_0057", s, 32'(dout[s]), 32'h00005757);
    access(s, 1'b0, 16'h0058, 16'h0000, -1, 1'b0);
    check_eq("b2b_0058", s, 32'(dout[s]), 32'h00005858);

    reset_mid_write(s, 16'h0057, 16'hDEAD);
    access(s, 1'b0, 16'h0057, 16'h0000, -1, 1'b0);
    check_eq("midrst_word_kept", s, 32'(dout[s]), 32'h00005757);

    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 7);
      idx  = 10'(($urandom_range(0, 15) * 37) % DEPTH);
      a    = {6'($urandom), idx};
      keep = (n == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      if (op == 0) begin
        access(s, 1'b1, a, 16'($urandom), $urandom_range(0, nwait(s)), 1'b0);
      end else if (op <= 3 || !written[s][int'(idx)]) begin
        access(s, 1'b1, a, 16'($urandom), -1, keep);
      end else begin
        access(s, 1'b0, a, 16'h0000, -1, keep);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s]      = 1'b1;
      mem_en[s]   = 1'b0;
      r_w[s]      = 1'b0;
      addr[s]     = 16'h0000;
      din[s]      = 16'h0000;
      exp_dout[s] = 16'h0000;
    end
    @(negedge clk);
    run_suite(0);
    run_suite(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
